// File: rtl/seq_divider_pkg.sv
// seq_divider shared definitions.
// Default width, FSM states and counter sizing.
package seq_divider_pkg;

  localparam int W_DEF = 4;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(2 * w) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider start/busy/done handshake bundle.
// master drives requests, slave returns results.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEF
);

  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient,
    input  remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient,
    output remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring division step:
// shift in a dividend bit, compare, subtract.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] i_r,
  input  logic         i_bit,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_r,
  output logic         o_q
);

  logic [W:0] w_t;

  assign w_t = {i_r, i_bit};
  assign o_q = (w_t >= {1'b0, i_d});
  // Difference is below D, so it fits W bits.
  assign o_r = o_q ? (w_t[W-1:0] - i_d)
                   : w_t[W-1:0];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, 2W/W -> 2W q, W r.
// One quotient bit per clock; divide-by-zero flagged.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic   clock,
  input  logic   reset,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_q;
  logic [W-1:0]   r_r;
  logic [W-1:0]   r_d;
  logic [2*W-1:0] r_quot;
  logic [W-1:0]   r_rem;
  logic           r_done;
  logic           r_dbz;

  logic           w_zero;
  logic           w_last;
  logic           w_qbit;
  logic [W-1:0]   w_r;

  assign w_zero = (bus.divisor == '0);
  assign w_last = (r_cnt == LAST);

  seq_divider_div_step #(.W(W)) u_step (
    .i_r   (r_r),
    .i_bit (r_q[2*W-1]),
    .i_d   (r_d),
    .o_r   (w_r),
    .o_q   (w_qbit)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start && !w_zero) w_next = RUN;
      RUN:  if (w_last) w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && w_zero) begin
            r_quot <= '1;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
            r_done <= 1'b1;
          end else if (bus.start) begin
            r_q   <= bus.dividend;
            r_r   <= '0;
            r_d   <= bus.divisor;
            r_cnt <= '0;
            r_dbz <= 1'b0;
          end
        end
        RUN: begin
          r_q   <= {r_q[2*W-2:0], w_qbit};
          r_r   <= w_r;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quot <= {r_q[2*W-2:0], w_qbit};
            r_rem  <= w_r;
            r_done <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider.
// Stimulus pushes expectations; monitor checks on done.
module tb_seq_divider;
  import seq_divider_pkg::*;

  localparam int W = W_DEF;
  localparam int N = 2 * W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    int           acc;
    int           bsy;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(bus.quotient), 32'(e.q));
        chk("remainder", 32'(bus.remainder), 32'(e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        chk("busy_cycles", 32'(busy_cnt), 32'(e.bsy));
      end
      busy_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] a,
                       input logic [W-1:0] b,
                       input logic [N-1:0] eq,
                       input logic [W-1:0] er,
                       input bit push);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.start = 1'b0;
    if (push) begin
      e.q   = eq;
      e.r   = er;
      e.dbz = (b == '0);
      e.acc = cyc;
      e.lat = (b == '0) ? 0 : N;
      e.bsy = (b == '0) ? 0 : N;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.done !== 1'b1) begin
      step();
      n++;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done expected within 40 cycles");
        return;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_quot"}, 32'(bus.quotient), 32'd0);
    chk({tag, "_rem"}, 32'(bus.remainder), 32'd0);
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    reset        = 1'b1;
    repeat (2) step();
    chk_zero("reset");
    reset = 1'b0;
    step();

    issue(8'd143, 4'd11, 8'd13, 4'd0, 1'b1);
    wait_done();
    step();

    issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b1);
    wait_done();
    step();

    issue(8'd200, 4'd0, 8'd255, 4'd0, 1'b1);
    wait_done();
    step();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b1);
    wait_done();
    step();

    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b1);
    repeat (2) step();
    issue(8'd99, 4'd3, 8'd0, 4'd0, 1'b0);
    wait_done();
    issue(8'd99, 4'd3, 8'd33, 4'd0, 1'b1);
    repeat (4) step();
    chk("held_quot", 32'(bus.quotient), 32'd28);
    chk("held_rem", 32'(bus.remainder), 32'd4);
    wait_done();
    step();

    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("abort");
    sb.delete();
    busy_cnt = 0;
    repeat (12) step();
    issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b1);
    wait_done();
    step();

    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        issue(N'(a), W'(b), N'(a / b), W'(a % b), 1'b1);
        wait_done();
      end
    end

    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d outstanding expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider, the inverse companion to the combinational Wallace-tree multiplier in the multdiv datapath. It takes a 2W-bit dividend, the width of a multiplier product, and a W-bit divisor. It produces a 2W-bit quotient and a W-bit remainder, one quotient bit per clock, under a start/busy/done handshake. A divide-by-zero is flagged rather than computed.

## Interface
Parameters:
- W, 4, divisor and remainder width; dividend and quotient are 2W bits.

Ports:
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- start  in  1  request; sampled only when idle.
- dividend  in  2W  numerator; captured on accepted start.
- divisor  in  W  denominator; captured on accepted start.
- busy  out  1  high while iterating.
- done  out  1  registered one-cycle pulse when results become valid.
- quotient  out  2W  result; held until next accepted start.
- remainder  out  W  result; held until next accepted start.
- div_by_zero  out  1  set with done when divisor was 0; held with results.

## Operation
- States: IDLE, RUN.
- IDLE, start=1, divisor≠0:
  - Latch dividend into shift register Q.
  - Clear partial remainder R (W+1 bits).
  - Latch divisor into D.
  - Clear count and div_by_zero.
  - Go to RUN; busy=1.
- IDLE, start=1, divisor=0:
  - Stay in IDLE.
  - On that edge: quotient=all ones, remainder=0, div_by_zero=1, done=1.
- RUN, each edge, one restoring step:
  - T = {R[W-1:0], Q[2W-1]}; Q shifts left.
  - If T ≥ D: R = T−D, new Q LSB = 1. Else R = T, LSB = 0.
  - count increments.
- On the edge performing step 2W:
  - quotient←Q final, remainder←R[W-1:0], done=1, busy=0.
  - Go to IDLE.
- start while busy is ignored. Operands on the inputs are don't-care outside the accepting edge.
- Invariant: R < D after every step, so remainder fits W bits and quotient fits 2W bits for any legal inputs.
- Unsigned only. No signed mode, no early termination.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE, count=0.
- Latency, nonzero divisor:
  - start sampled at edge 0.
  - Steps at edges 1..2W.
  - done high during the cycle after edge 2W: 2W edges after accept, 8 for W=4.
- Latency, zero divisor: done high the cycle after the sampling edge (1 edge).
- done is high for exactly one cycle. Any edge not asserting it clears it.
- busy is high from edge 0 through the cycle before done.
- Back-to-back: state is IDLE in the done cycle, so start asserted in that cycle is accepted. The next operation begins without a gap, and the previous results stay on the outputs until that operation's done.
- Reset mid-operation: on the reset edge the operation is aborted and all outputs return to reset values. No done pulse occurs.
- Simultaneous reset and start: reset wins; start is ignored.

## Structure
- Shared package holds:
  - the default W;
  - the state enum IDLE/RUN;
  - the count width ($clog2(2W)+1).
- Sub-module div_step (combinational): inputs R, next dividend bit, D; outputs next R and quotient bit. This is the compare-and-conditional-subtract cell.
- Top module holds the FSM, counter, Q/R/D registers and output registers.
- W is a parameter throughout; no hard-coded 4/8 outside the package default.

## Test plan
- Exact division: dividend=143, divisor=11, W=4 -> done 8 edges after accept, quotient=13, remainder=0, div_by_zero=0; busy high for those 8 cycles.
- Dividend smaller than divisor: dividend=5, divisor=9 -> quotient=0, remainder=5.
- Divide-by-zero and maximum case:
  - dividend=200, divisor=0 -> done one edge later, quotient=255, remainder=0, div_by_zero=1, busy never high.
  - Then dividend=255, divisor=1 -> quotient=255, remainder=0, div_by_zero cleared.
- Handshake:
  - 200/7 started; start pulsed again with 99/3 at edge 3 -> ignored, result 28 r 4.
  - Start 99/3 in the done cycle -> accepted, 28 r 4 held until done, then 33 r 0.
- Reset mid-operation: start 225/15, reset at edge 4 -> all outputs 0 the next cycle, no done pulse. A fresh 225/15 then yields 15 r 0.
- Exhaustive (W=4): all dividend 0..255 × divisor 1..15 back-to-back, checked against the golden model (quotient*divisor+remainder == dividend, remainder<divisor).
